// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Purpose:
//   Instruction fetch unit. Drives the instruction ROM (chip enable plus an
//   8-byte aligned address), captures each returned 64-bit word together with
//   its PC into a small FIFO, and presents the FIFO head to decode through a
//   valid/ready handshake. A one-cycle branch redirect flushes the FIFO and
//   restarts fetching at the aligned target.
//
// Parameters:
//   DEPTH         fetch FIFO entries (power of two, >= 2)
//   RESET_PC      first fetch address (low 3 bits zero)
//
// Ports:
//   clk           clock, all state on the rising edge
//   rst           asynchronous active-low reset
//   rom_ce        ROM chip enable (1 = enabled)
//   rom_addr      ROM byte address, 8-byte aligned, 0 while rom_ce is low
//   rom_inst      ROM read data, combinational from rom_addr
//   branch_flag   one-cycle redirect request
//   branch_target redirect byte address (low 3 bits ignored)
//   id_ready      decode accepts the head entry this cycle
//   id_valid      FIFO non-empty (driven from registers only)
//   id_pc         PC of the head entry, 0 when empty
//   id_inst       instruction of the head entry, 0 when empty
//   fetch_count   number of pushes, wraps at 2^32 (only with IF_FETCH_COUNT_EN)
//
// Build option:
//   IF_FETCH_COUNT_EN  when defined, adds the fetch_count port and counter.
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [63:0] rom_inst,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [63:0] id_inst
`ifdef IF_FETCH_COUNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    logic             rom_ce_q;
    logic [31:0]      pc_q,     pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // FIFO storage is never reset: its contents are masked by count_q.
    logic [31:0]      pc_mem_q   [DEPTH];
    logic [63:0]      inst_mem_q [DEPTH];

    logic             push;
    logic             pop;

    assign id_valid = (count_q != '0);

    // A redirect wins over everything: the same-cycle fetch is dropped and a
    // concurrent id_ready is not treated as a pop.
    assign pop  = id_valid & id_ready & ~branch_flag;
    assign push = rom_ce_q & ~branch_flag & ((count_q < DEPTH_C) | pop);

    assign rom_ce   = rom_ce_q;
    assign rom_addr = rom_ce_q ? pc_q : 32'h0;
    assign id_pc    = id_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;
    assign id_inst  = id_valid ? inst_mem_q[rd_ptr_q] : 64'h0;

    // Next-state for PC, pointers and occupancy.
    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (branch_flag) begin
            // Masking instead of slicing keeps every target bit in use.
            pc_d     = branch_target & ~32'h7;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                pc_d     = pc_q + 32'd8;   // modulo 2^32
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control FSM; rom_ce is registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rom_ce_q <= 1'b0;
        end else if (branch_flag) begin
            state_q  <= FETCH;
            rom_ce_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q  <= FETCH;
                    rom_ce_q <= 1'b1;
                end
                FETCH: begin
                    rom_ce_q <= 1'b1;
                    if ((count_d == DEPTH_C) && !pop) begin
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    rom_ce_q <= 1'b1;
                    if (pop) begin
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    rom_ce_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= pc_q;
            inst_mem_q[wr_ptr_q] <= rom_inst;
        end
    end

`ifdef IF_FETCH_COUNT_EN
    logic [31:0] fetch_count_q;

    // Counts accepted fetches only; redirects do not clear it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count_q <= 32'h0;
        end else if (push) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//
// Self-checking bench for inst_fetch (DEPTH=2, RESET_PC=0). A behavioural ROM
// answers rom_addr combinationally. A per-cycle vector table drives
// id_ready/branch_flag/branch_target and states the outputs expected after the
// following clock edge; a scoreboard queue of expected PCs (loaded whenever the
// bench starts or redirects the stream) is checked at every handshake.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [63:0] rom_inst;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [63:0] id_inst;
`ifdef IF_FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    inst_fetch #(
        .DEPTH    (2),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rom_ce        (rom_ce),
        .rom_addr      (rom_addr),
        .rom_inst      (rom_inst),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .id_ready      (id_ready),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_inst       (id_inst)
`ifdef IF_FETCH_COUNT_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    function automatic logic [63:0] rom_word(input logic [31:0] a);
        if (a == 32'h0) return 64'h2010820000000000;
        return {a ^ 32'hDEAD_0000, ~a};
    endfunction

    always_comb rom_inst = rom_word(rom_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard of PCs expected at the decode handshake.
    logic [31:0] exp_q[$];

    task automatic sb_restart(input logic [31:0] start);
        logic [31:0] p;
        p = start;
        exp_q.delete();
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(p);
            p = p + 32'd8;
        end
    endtask

    // Called with the inputs for the coming edge already driven.
    task automatic sb_pop_check(input string tag);
        logic [31:0] e;
        if (id_valid && id_ready && !branch_flag) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s sb_empty: got pc %h expected no delivery", tag, id_pc);
            end else begin
                e = exp_q.pop_front();
                chk({tag, " sb_pc"}, {32'h0, id_pc}, {32'h0, e});
                chk({tag, " sb_inst"}, id_inst, rom_word(e));
            end
        end
    endtask

    typedef struct {
        logic        rdy;
        logic        br;
        logic [31:0] tgt;
        logic        e_ce;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pc;
        logic [31:0] e_fc;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic br, input logic [31:0] tgt,
                                input logic ce, input logic [31:0] addr, input logic vld,
                                input logic [31:0] pc, input logic [31:0] fc);
        vec_t v;
        v.rdy = rdy; v.br = br; v.tgt = tgt;
        v.e_ce = ce; v.e_addr = addr; v.e_vld = vld; v.e_pc = pc; v.e_fc = fc;
        return v;
    endfunction

    vec_t vecs[18];

    task automatic check_outputs(input string tag, input logic ce, input logic [31:0] addr,
                                 input logic vld, input logic [31:0] pc, input logic [31:0] fc);
        chk({tag, " rom_ce"},   {63'h0, rom_ce},    {63'h0, ce});
        chk({tag, " rom_addr"}, {32'h0, rom_addr},  {32'h0, addr});
        chk({tag, " id_valid"}, {63'h0, id_valid},  {63'h0, vld});
        chk({tag, " id_pc"},    {32'h0, id_pc},     {32'h0, pc});
        chk({tag, " id_inst"},  id_inst,            vld ? rom_word(pc) : 64'h0);
`ifdef IF_FETCH_COUNT_EN
        chk({tag, " fetch_count"}, {32'h0, fetch_count}, {32'h0, fc});
`else
        if (fc == 32'hFFFF_FFFF) $display("note: %s unused count", tag);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //             rdy  br   tgt            ce   addr           vld  pc             fc
        vecs[0]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'd0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'd1);
        vecs[2]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0010, 1'b1, 32'h0000_0000, 32'd2);
        vecs[3]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0010, 1'b1, 32'h0000_0000, 32'd2);
        vecs[4]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0010, 1'b1, 32'h0000_0000, 32'd2);
        vecs[5]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0018, 1'b1, 32'h0000_0008, 32'd3);
        vecs[6]  = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0020, 1'b1, 32'h0000_0010, 32'd4);
        vecs[7]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0020, 1'b1, 32'h0000_0010, 32'd4);
        vecs[8]  = mk(1'b0, 1'b1, 32'h0000_001D, 1'b1, 32'h0000_0018, 1'b0, 32'h0000_0000, 32'd4);
        vecs[9]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0020, 1'b1, 32'h0000_0018, 32'd5);
        vecs[10] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0028, 1'b1, 32'h0000_0018, 32'd6);
        vecs[11] = mk(1'b1, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0040, 1'b0, 32'h0000_0000, 32'd6);
        vecs[12] = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0048, 1'b1, 32'h0000_0040, 32'd7);
        vecs[13] = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0050, 1'b1, 32'h0000_0048, 32'd8);
        vecs[14] = mk(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0000_0000, 32'd8);
        vecs[15] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFF8, 32'd9);
        vecs[16] = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000, 32'd10);
        vecs[17] = mk(1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008, 32'd11);

        // Held in reset.
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'd0);

        rst = 1'b1;
        sb_restart(32'h0000_0000);

        for (int i = 0; i < 18; i++) begin
            id_ready      = vecs[i].rdy;
            branch_flag   = vecs[i].br;
            branch_target = vecs[i].tgt;
            if (vecs[i].br) sb_restart(vecs[i].tgt & ~32'h7);
            sb_pop_check($sformatf("v%0d", i));
            @(posedge clk);
            #1;
            check_outputs($sformatf("v%0d", i), vecs[i].e_ce, vecs[i].e_addr,
                          vecs[i].e_vld, vecs[i].e_pc, vecs[i].e_fc);
        end

        // Asynchronous reset mid-stream, between clock edges.
        branch_flag = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_outputs("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'd0);

        @(posedge clk);
        #1;
        rst      = 1'b1;
        id_ready = 1'b1;
        sb_restart(32'h0000_0000);
        @(posedge clk);
        #1;
        check_outputs("restart e1", 1'b1, 32'h0, 1'b0, 32'h0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            sb_pop_check($sformatf("restart k%0d", k));
            @(posedge clk);
            #1;
            check_outputs($sformatf("restart k%0d", k), 1'b1, 32'(k * 8 + 8), 1'b1,
                          32'(k * 8), 32'(k + 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
